// File: rtl/render_pkg.sv
// Shared types for the wireframe renderer: vertex/triangle records and scheduler states.
package render_pkg;

  localparam int VTX_W = 10;

  // [0] = x, [1] = y
  typedef logic [1:0][VTX_W-1:0] vertex_t;

  typedef struct packed {
    vertex_t v3;
    vertex_t v2;
    vertex_t v1;
  } tri_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    RDWAIT,
    LATCH,
    START,
    RELEASE,
    NEXT,
    FINISH
  } sched_state_t;

endpackage

// File: rtl/tri_area_zero.sv
// Combinational zero-area test on a screen-space triangle (twice the signed area == 0).
module tri_area_zero
  import render_pkg::*;
(
  input  vertex_t v1,
  input  vertex_t v2,
  input  vertex_t v3,
  output logic    zero
);

  logic signed [VTX_W:0]     dx21, dy31, dy21, dx31;
  logic signed [2*VTX_W+1:0] p1, p2;
  logic signed [2*VTX_W+2:0] area;

  always_comb begin
    dx21 = (VTX_W+1)'(v2[0]) - (VTX_W+1)'(v1[0]);
    dy31 = (VTX_W+1)'(v3[1]) - (VTX_W+1)'(v1[1]);
    dy21 = (VTX_W+1)'(v2[1]) - (VTX_W+1)'(v1[1]);
    dx31 = (VTX_W+1)'(v3[0]) - (VTX_W+1)'(v1[0]);
    p1   = (2*VTX_W+2)'(dx21) * (2*VTX_W+2)'(dy31);
    p2   = (2*VTX_W+2)'(dy21) * (2*VTX_W+2)'(dx31);
    area = (2*VTX_W+3)'(p1) - (2*VTX_W+3)'(p2);
    zero = (area == '0);
  end

endmodule

// File: rtl/triangle_scheduler.sv
// Frame sequencer: walks the triangle list, culls degenerate triangles and runs one
// draw_triangle Start/Done handshake per remaining triangle.
module triangle_scheduler
  import render_pkg::*;
#(
  parameter int TRI_AW  = 10,
  parameter int MEM_LAT = 1,
  parameter int CULL_EN = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_Start,
  input  logic [TRI_AW:0]   tri_count,
  input  logic [TRI_AW-1:0] base_addr,
  output logic [TRI_AW-1:0] mem_addr,
  input  logic [59:0]       mem_rdata,
  output logic [1:0][9:0]   V1,
  output logic [1:0][9:0]   V2,
  output logic [1:0][9:0]   V3,
  output logic              draw_triangle_Start,
  input  logic              draw_triangle_Done,
  output logic              busy,
  output logic              frame_Done,
  output logic              frame_overrun,
  output logic [TRI_AW:0]   tri_drawn,
  output logic [TRI_AW:0]   tri_culled
);

  localparam logic [TRI_AW:0] CNT_ONE = {{TRI_AW{1'b0}}, 1'b1};
  localparam logic [TRI_AW:0] CNT_MAX = '1;

  sched_state_t      state_q, state_d;
  logic [TRI_AW:0]   count_q, count_d;
  logic [TRI_AW:0]   idx_q, idx_d;
  logic [TRI_AW-1:0] base_q, base_d;
  logic [TRI_AW-1:0] addr_q, addr_d;
  logic [1:0]        wait_q, wait_d;
  tri_t              tri_q, tri_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic [TRI_AW:0]   drawn_q, drawn_d;
  logic [TRI_AW:0]   culled_q, culled_d;
  logic              area_zero;

  tri_area_zero u_area (
    .v1   (tri_q.v1),
    .v2   (tri_q.v2),
    .v3   (tri_q.v3),
    .zero (area_zero)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      wait_q    <= '0;
      tri_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      drawn_q   <= '0;
      culled_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      wait_q    <= wait_d;
      tri_q     <= tri_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      drawn_q   <= drawn_d;
      culled_q  <= culled_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    base_d    = base_q;
    addr_d    = addr_q;
    wait_d    = wait_q;
    tri_d     = tri_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    drawn_d   = drawn_q;
    culled_d  = culled_q;

    // Any request outside IDLE (FINISH included) is dropped and remembered.
    if (frame_Start && state_q != IDLE) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (frame_Start) begin
          count_d   = tri_count;
          base_d    = base_addr;
          idx_d     = '0;
          drawn_d   = '0;
          culled_d  = '0;
          overrun_d = 1'b0;
          busy_d    = 1'b1;
          if (tri_count == '0) begin
            state_d = FINISH;
          end else begin
            addr_d  = base_addr;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        wait_d  = 2'd1;
        state_d = RDWAIT;
      end
      RDWAIT: begin
        // Vertices are captured on the last wait cycle so they are stable from LATCH on.
        if (wait_q == 2'(MEM_LAT)) begin
          tri_d   = tri_t'(mem_rdata);
          state_d = LATCH;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      LATCH: begin
        if (CULL_EN != 0 && area_zero) begin
          if (culled_q != CNT_MAX) culled_d = culled_q + CNT_ONE;
          state_d = NEXT;
        end else begin
          state_d = START;
        end
      end
      START: begin
        if (draw_triangle_Done) state_d = RELEASE;
      end
      RELEASE: begin
        if (!draw_triangle_Done) begin
          if (drawn_q != CNT_MAX) drawn_d = drawn_q + CNT_ONE;
          state_d = NEXT;
        end
      end
      NEXT: begin
        idx_d = idx_q + CNT_ONE;
        if (idx_d == count_q) begin
          state_d = FINISH;
        end else begin
          addr_d  = base_q + idx_d[TRI_AW-1:0];
          state_d = FETCH;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr            = addr_q;
  assign V1                  = tri_q.v1;
  assign V2                  = tri_q.v2;
  assign V3                  = tri_q.v3;
  assign draw_triangle_Start = (state_q == START);
  assign busy                = busy_q;
  assign frame_Done          = done_q;
  assign frame_overrun       = overrun_q;
  assign tri_drawn           = drawn_q;
  assign tri_culled          = culled_q;

endmodule
